// File: rtl/npu_pkg.sv
// npu_pkg: shared types and defaults for the NPU instruction issuer.
//   issuer_state_t : op sequencing states (IDLE, START, LOAD, COMPUTE, WB)
//   npu_op_t       : buffered op descriptor at the default 8-bit word width
//   START_OP_DEFAULT / NOP_OP_DEFAULT : default scheduler start and filler words
package npu_pkg;

    localparam int unsigned NPU_W_IN = 8;

    localparam logic [NPU_W_IN-1:0] START_OP_DEFAULT = 8'hA5;
    localparam logic [NPU_W_IN-1:0] NOP_OP_DEFAULT   = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_LOAD    = 3'd2,
        S_COMPUTE = 3'd3,
        S_WB      = 3'd4
    } issuer_state_t;

    typedef struct packed {
        logic                last;
        logic [NPU_W_IN-1:0] compute_word;
        logic [NPU_W_IN-1:0] load_word;
    } npu_op_t;

endpackage

// File: rtl/npu_op_fifo.sv
// npu_op_fifo: synchronous FIFO holding op descriptors as flat words.
//   clk, rst        : clock, synchronous active-high reset (flushes pointers)
//   push, wr_data   : write request and data (ignored when full)
//   pop             : advance head (ignored when empty)
//   rd_data         : current head entry (valid when !empty)
//   full, empty     : occupancy flags
//   count           : occupied entries, 0..DEPTH
module npu_op_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_instr_issuer.sv
// npu_instr_issuer: buffers op descriptors and replays each as a 4-word
// sequence START_OP, load word, compute word, NOP_OP on the scheduler instr bus.
//   clk, rst_n      : clock, synchronous active-high reset
//   op_valid/ready  : descriptor handshake (ready = FIFO not full, low in reset)
//   op_load_word    : word driven while in S_LOAD
//   op_compute_word : word driven while in S_COMPUTE
//   op_last         : descriptor closes a batch
//   issue_en        : permission to start a new op (sampled in S_IDLE / S_WB)
//   instr           : registered word to npu_scheduler
//   busy            : sequence in flight
//   batch_done      : 1-cycle pulse after WB of a last descriptor
//   fifo_count      : occupied FIFO entries
module npu_instr_issuer
    import npu_pkg::*;
#(
    parameter int unsigned          W_IN     = 8,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [W_IN-1:0]      START_OP = W_IN'(START_OP_DEFAULT),
    parameter logic [W_IN-1:0]      NOP_OP   = W_IN'(NOP_OP_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [W_IN-1:0]         op_load_word,
    input  logic [W_IN-1:0]         op_compute_word,
    input  logic                    op_last,
    input  logic                    issue_en,
    output logic [W_IN-1:0]         instr,
    output logic                    busy,
    output logic                    batch_done,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic            last;
        logic [W_IN-1:0] compute_word;
        logic [W_IN-1:0] load_word;
    } op_t;

    issuer_state_t   state;
    issuer_state_t   state_next;
    op_t             wr_op;
    op_t             head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after_pop;
    logic [W_IN-1:0] instr_next;

    assign wr_op    = '{last: op_last, compute_word: op_compute_word, load_word: op_load_word};
    assign op_ready = !full && !rst_n;
    assign push     = op_valid && op_ready;
    assign pop      = (state == S_WB);
    assign busy     = (state != S_IDLE);

    // Occupancy after the WB pop, including a same-edge push, so a descriptor
    // arriving on the pop edge chains straight into S_START without a gap.
    assign count_after_pop = fifo_count - CW'(1) + CW'(push);

    npu_op_fifo #(
        .WIDTH ($bits(op_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_n),
        .push    (push),
        .wr_data (wr_op),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!empty && issue_en) state_next = S_START;
            S_START:   state_next = S_LOAD;
            S_LOAD:    state_next = S_COMPUTE;
            S_COMPUTE: state_next = S_WB;
            S_WB:      state_next = (count_after_pop != '0 && issue_en) ? S_START : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // instr is loaded from the next state so it lines up with the state itself.
    always_comb begin
        instr_next = NOP_OP;
        case (state_next)
            S_START:   instr_next = START_OP;
            S_LOAD:    instr_next = head.load_word;
            S_COMPUTE: instr_next = head.compute_word;
            default:   instr_next = NOP_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            instr      <= NOP_OP;
            batch_done <= 1'b0;
        end else begin
            state      <= state_next;
            instr      <= instr_next;
            batch_done <= pop && head.last;
        end
    end

endmodule

// File: tb/tb_npu_instr_issuer.sv
// tb_npu_instr_issuer: directed-vector bench for npu_instr_issuer.
module tb_npu_instr_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_load_word;
    logic [7:0] op_compute_word;
    logic       op_last;
    logic       issue_en;
    logic [7:0] instr;
    logic       busy;
    logic       batch_done;
    logic [2:0] fifo_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    npu_instr_issuer #(
        .W_IN     (8),
        .DEPTH    (4),
        .START_OP (8'hA5),
        .NOP_OP   (8'h00)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_load_word    (op_load_word),
        .op_compute_word (op_compute_word),
        .op_last         (op_last),
        .issue_en        (issue_en),
        .instr           (instr),
        .busy            (busy),
        .batch_done      (batch_done),
        .fifo_count      (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [7:0] i, input logic b, input logic bd);
        step();
        check({tag, ".instr"}, instr, i);
        check({tag, ".busy"}, busy, b);
        check({tag, ".bdone"}, batch_done, bd);
    endtask

    task automatic push_op(input logic [7:0] l, input logic [7:0] c, input logic last);
        op_valid        = 1'b1;
        op_load_word    = l;
        op_compute_word = c;
        op_last         = last;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; op_valid = 1'b0; op_load_word = '0; op_compute_word = '0;
        op_last = 1'b0; issue_en = 1'b0;

        // reset
        step(); step();
        check("rst.ready", op_ready, 0);
        check("rst.instr", instr, 8'h00);
        check("rst.busy", busy, 0);
        check("rst.count", fifo_count, 0);
        rst_n = 1'b0;
        step();
        check("rst.ready_after", op_ready, 1);
        check("rst.bdone", batch_done, 0);

        // 1: single op
        issue_en = 1'b1;
        push_op(8'h15, 8'h3C, 1'b1);
        check("t1.count", fifo_count, 1);
        check("t1.idle", instr, 8'h00);
        expect_cyc("t1.s", 8'hA5, 1, 0);
        expect_cyc("t1.l", 8'h15, 1, 0);
        expect_cyc("t1.c", 8'h3C, 1, 0);
        expect_cyc("t1.w", 8'h00, 1, 0);
        expect_cyc("t1.bd", 8'h00, 0, 1);
        expect_cyc("t1.after", 8'h00, 0, 0);
        check("t1.count_end", fifo_count, 0);

        // 2: three ops back to back
        issue_en = 1'b0;
        push_op(8'h11, 8'h21, 1'b0);
        push_op(8'h12, 8'h22, 1'b0);
        push_op(8'h13, 8'h23, 1'b1);
        check("t2.count", fifo_count, 3);
        issue_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_cyc("t2.s", 8'hA5, 1, 0);
            expect_cyc("t2.l", 8'(8'h10 + i), 1, 0);
            expect_cyc("t2.c", 8'(8'h20 + i), 1, 0);
            expect_cyc("t2.w", 8'h00, 1, 0);
        end
        expect_cyc("t2.bd", 8'h00, 0, 1);
        expect_cyc("t2.after", 8'h00, 0, 0);

        // 3: fill FIFO, fifth op held until first pop
        issue_en = 1'b0;
        op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_load_word    = 8'(8'h30 + i);
            op_compute_word = 8'(8'h40 + i);
            op_last         = 1'b0;
            check("t3.ready_fill", op_ready, 1);
            step();
        end
        op_load_word = 8'h34; op_compute_word = 8'h44; op_last = 1'b1;
        check("t3.ready_full", op_ready, 0);
        check("t3.count_full", fifo_count, 4);
        step();
        check("t3.held", fifo_count, 4);
        issue_en = 1'b1;
        expect_cyc("t3.s0", 8'hA5, 1, 0);
        expect_cyc("t3.l0", 8'h30, 1, 0);
        expect_cyc("t3.c0", 8'h40, 1, 0);
        expect_cyc("t3.w0", 8'h00, 1, 0);
        check("t3.ready_wb", op_ready, 0);
        expect_cyc("t3.s1", 8'hA5, 1, 0);
        check("t3.count_pop", fifo_count, 3);
        check("t3.ready_pop", op_ready, 1);
        expect_cyc("t3.l1", 8'h31, 1, 0);
        check("t3.count_push", fifo_count, 4);
        op_valid = 1'b0;
        expect_cyc("t3.c1", 8'h41, 1, 0);
        expect_cyc("t3.w1", 8'h00, 1, 0);
        for (int i = 2; i <= 4; i++) begin
            expect_cyc("t3.s", 8'hA5, 1, 0);
            expect_cyc("t3.l", 8'(8'h30 + i), 1, 0);
            expect_cyc("t3.c", 8'(8'h40 + i), 1, 0);
            expect_cyc("t3.w", 8'h00, 1, 0);
        end
        expect_cyc("t3.bd", 8'h00, 0, 1);
        check("t3.count_end", fifo_count, 0);

        // 4: issue_en dropped during COMPUTE
        issue_en = 1'b0;
        push_op(8'h51, 8'h61, 1'b0);
        push_op(8'h52, 8'h62, 1'b1);
        issue_en = 1'b1;
        expect_cyc("t4.s1", 8'hA5, 1, 0);
        expect_cyc("t4.l1", 8'h51, 1, 0);
        expect_cyc("t4.c1", 8'h61, 1, 0);
        issue_en = 1'b0;
        expect_cyc("t4.w1", 8'h00, 1, 0);
        expect_cyc("t4.idle1", 8'h00, 0, 0);
        expect_cyc("t4.idle2", 8'h00, 0, 0);
        check("t4.count_wait", fifo_count, 1);
        issue_en = 1'b1;
        expect_cyc("t4.s2", 8'hA5, 1, 0);
        expect_cyc("t4.l2", 8'h52, 1, 0);
        expect_cyc("t4.c2", 8'h62, 1, 0);
        expect_cyc("t4.w2", 8'h00, 1, 0);
        expect_cyc("t4.bd", 8'h00, 0, 1);

        // 5: reset during LOAD
        issue_en = 1'b0;
        push_op(8'h71, 8'h81, 1'b1);
        push_op(8'h72, 8'h82, 1'b1);
        issue_en = 1'b1;
        expect_cyc("t5.s", 8'hA5, 1, 0);
        expect_cyc("t5.l", 8'h71, 1, 0);
        rst_n = 1'b1;
        expect_cyc("t5.rst", 8'h00, 0, 0);
        check("t5.count", fifo_count, 0);
        check("t5.ready", op_ready, 0);
        rst_n = 1'b0;
        expect_cyc("t5.idle", 8'h00, 0, 0);
        push_op(8'h75, 8'h85, 1'b1);
        expect_cyc("t5.s2", 8'hA5, 1, 0);
        expect_cyc("t5.l2", 8'h75, 1, 0);
        expect_cyc("t5.c2", 8'h85, 1, 0);
        expect_cyc("t5.w2", 8'h00, 1, 0);
        expect_cyc("t5.bd", 8'h00, 0, 1);

        // 6: push coinciding with the pop at count 1
        push_op(8'h91, 8'hA1, 1'b0);
        expect_cyc("t6.s1", 8'hA5, 1, 0);
        expect_cyc("t6.l1", 8'h91, 1, 0);
        expect_cyc("t6.c1", 8'hA1, 1, 0);
        expect_cyc("t6.w1", 8'h00, 1, 0);
        op_valid = 1'b1; op_load_word = 8'h92; op_compute_word = 8'hA2; op_last = 1'b1;
        check("t6.ready", op_ready, 1);
        expect_cyc("t6.s2", 8'hA5, 1, 0);
        op_valid = 1'b0;
        check("t6.count", fifo_count, 1);
        expect_cyc("t6.l2", 8'h92, 1, 0);
        expect_cyc("t6.c2", 8'hA2, 1, 0);
        expect_cyc("t6.w2", 8'h00, 1, 0);
        expect_cyc("t6.bd", 8'h00, 0, 1);
        check("t6.count_end", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
